// File: rtl/fifo_stream_reader.sv
// Pops a registered-read FIFO into a valid/ready stream through a 3-entry skid buffer.
// Latency: read in N, data N+1, out_valid N+2; reads stop once occ+inflight reaches 3, so a stall never drops a word.
module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 fifo_read_enb,
  input  logic [WIDTH-1:0]     fifo_data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] word_count
);

  logic [WIDTH-1:0] buffer [3];
  logic [1:0]       head;
  logic [1:0]       tail;
  logic [1:0]       occ;
  logic             inflight;

  logic             pop;
  logic [1:0]       head_nxt;
  logic [1:0]       occ_nxt;
  logic [2:0]       committed;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Every in-flight word already owns a slot, so a capture can never hit a full buffer.
  assign committed     = {1'b0, occ} + {2'b00, inflight};
  assign fifo_read_enb = enable & ~fifo_empty & ~reset & (committed < 3'd3);

  assign pop      = out_valid & out_ready;
  assign head_nxt = pop ? wrap_inc(head) : head;
  assign occ_nxt  = occ + {1'b0, inflight} - {1'b0, pop};

  always_ff @(posedge clock) begin
    if (reset) begin
      head       <= 2'd0;
      tail       <= 2'd0;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      word_count <= '0;
    end else begin
      inflight <= fifo_read_enb;
      if (inflight) begin
        buffer[tail] <= fifo_data_out;
        tail         <= wrap_inc(tail);
      end
      head      <= head_nxt;
      occ       <= occ_nxt;
      out_valid <= (occ_nxt != 2'd0);
      if (pop)
        word_count <= word_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      // Bypass the arriving word when it lands straight in the head slot of a drained buffer.
      if (occ_nxt != 2'd0)
        out_data <= (inflight && (tail == head_nxt)) ? fifo_data_out : buffer[head_nxt];
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural registered-read FIFO, scoreboard monitor, vector table and corner sequences.
module tb_fifo_stream_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        out_ready = 1'b0;
  logic        fifo_empty;
  logic        fifo_read_enb;
  logic [7:0]  fifo_data_out;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [15:0] word_count;
  logic        rd4;
  logic        ov4;
  logic [7:0]  od4;
  logic [3:0]  wc4;

  logic [7:0]  mem [0:255];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          rd_issued = 0;
  logic [7:0]  exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          hs_cnt = 0;
  logic [15:0] exp_wc = 16'd0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_dat = 8'd0;

  typedef struct {
    bit         push;
    logic [7:0] pdat;
    bit         en;
    bit         rdy;
    bit         e_rd;
    bit         e_vld;
    bit         chk_dat;
    logic [7:0] e_dat;
    logic [15:0] e_wc;
  } vec_t;

  fifo_stream_reader #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_read_enb(fifo_read_enb), .fifo_data_out(fifo_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .word_count(word_count)
  );

  fifo_stream_reader #(.WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_read_enb(rd4), .fifo_data_out(fifo_data_out),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .word_count(wc4)
  );

  always #5 clock = ~clock;

  // Registered-read FIFO model: data valid the cycle after a read, high-Z otherwise.
  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clock) begin
    if (reset) begin
      rd_cnt        <= wr_cnt;
      fifo_data_out <= 'z;
    end else if (fifo_read_enb) begin
      fifo_data_out <= mem[rd_cnt % 256];
      rd_cnt        <= rd_cnt + 1;
      rd_issued     <= rd_issued + 1;
    end else begin
      fifo_data_out <= 'z;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    logic [7:0] e;
    if (reset) begin
      prev_stall = 1'b0;
      exp_wc     = 16'd0;
    end else begin
      if (fifo_empty)
        chk("read_while_empty", {31'd0, fifo_read_enb}, 32'd0);
      if (prev_stall) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {24'd0, out_data}, {24'd0, prev_dat});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got word %0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", {24'd0, out_data}, {24'd0, e});
        end
        chk("sb_word_count", {16'd0, word_count}, {16'd0, exp_wc});
        chk("sb_word_count4", {28'd0, wc4}, {28'd0, exp_wc[3:0]});
        exp_wc = exp_wc + 16'd1;
        hs_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_cnt % 256] = v;
    wr_cnt++;
    exp_q.push_back(v);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
    chk({tag, "_word_count"}, {16'd0, word_count}, 32'd0);
    chk({tag, "_word_count4"}, {28'd0, wc4}, 32'd0);
    chk({tag, "_read_enb"}, {31'd0, fifo_read_enb}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t expected finish", $time);
    $fatal(1);
  end

  initial begin
    vec_t vecs [5];
    int   base;
    int   hsb;
    int   n;

    // Single word 0xA5 straight after reset release.
    vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 16'd0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1};

    // Reset state, including a non-empty FIFO with enable high during reset.
    reset = 1'b1;
    tick();
    tick();
    enable = 1'b1;
    push(8'hEE);
    @(negedge clock);
    chk_reset_state("reset");
    exp_q.delete();
    tick();
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].push) push(vecs[i].pdat);
      enable    = vecs[i].en;
      out_ready = vecs[i].rdy;
      @(negedge clock);
      chk($sformatf("vec%0d_read_enb", i), {31'd0, fifo_read_enb}, {31'd0, vecs[i].e_rd});
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_vld});
      if (vecs[i].chk_dat)
        chk($sformatf("vec%0d_out_data", i), {24'd0, out_data}, {24'd0, vecs[i].e_dat});
      chk($sformatf("vec%0d_word_count", i), {16'd0, word_count}, {16'd0, vecs[i].e_wc});
      tick();
    end

    // Burst of five words: five back-to-back valid cycles.
    for (int v = 1; v <= 5; v++) push(v[7:0]);
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    n = 0;
    while (out_valid && n < 10) begin tick(); n++; end
    chk("burst_len", n, 32'd5);
    wait_drain("burst_drain", 20);

    // Backpressure: eight words queued, only three reads before stalling.
    out_ready = 1'b0;
    base = rd_issued;
    for (int i = 0; i < 8; i++) push(8'h10 + i[7:0]);
    repeat (8) tick();
    chk("bp_reads", rd_issued - base, 32'd3);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_word0", {24'd0, out_data}, 32'h10);
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_no_read_full", {31'd0, fifo_read_enb}, 32'd0);
    tick();
    @(negedge clock);
    chk("bp_reassert", {31'd0, fifo_read_enb}, 32'd1);
    wait_drain("bp_drain", 50);

    // enable drops the cycle after a read: in-flight word still arrives.
    tick();
    base = rd_issued;
    hsb  = hs_cnt;
    for (int i = 0; i < 3; i++) push(8'h20 + i[7:0]);
    tick();
    enable = 1'b0;
    repeat (6) tick();
    chk("en_reads", rd_issued - base, 32'd1);
    chk("en_delivered", hs_cnt - hsb, 32'd1);
    chk("en_pending", exp_q.size(), 32'd2);
    enable = 1'b1;
    wait_drain("en_resume", 30);

    // Reset with occ=2 and a read in flight.
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h30 + i[7:0]);
    repeat (3) tick();
    chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    exp_q.delete();
    tick();
    @(negedge clock);
    chk_reset_state("mid_reset");
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    hsb = hs_cnt;
    push(8'h3C);
    wait_drain("mid_post_drain", 20);
    chk("mid_post_count", hs_cnt - hsb, 32'd1);

    // Counter wrap on the 4-bit instance.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 17; i++) push(8'h40 + i[7:0]);
    wait_drain("wrap_drain", 60);
    chk("wrap_count4", {28'd0, wc4}, 32'd1);
    chk("wrap_count16", {16'd0, word_count}, 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
